// File: rtl/run_monitor_pkg.sv
// Shared types and default parameter values for the CPU run monitor.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_TIMEOUT
    } state_t;

    localparam int unsigned DEF_CNT_W       = 32;
    localparam int unsigned DEF_TIMEOUT     = 1000;
    localparam logic [3:0]  DEF_FETCH_STAT  = 4'd0;
    localparam int unsigned DEF_HALT_REPEAT = 3;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned STAT_W = 4;
    localparam int unsigned REP_W  = 4;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Watches a CPU's control state and PC, counts cycles/fetches/redirects and
// declares PASS on a repeated-PC halt or TIMEOUT when the cycle budget runs out.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter logic [3:0]  FETCH_STAT  = DEF_FETCH_STAT,
    parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [STAT_W-1:0] watch_stat,
    input  logic [PC_W-1:0]   watch_pc,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic [PC_W-1:0]   last_pc
);

    state_t            state;
    logic [STAT_W-1:0] prev_stat;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_next;
    logic              in_run;
    logic              start;
    logic              fetch;
    logic              first;
    logic              repeat_pc;
    logic              redir;
    logic              halt;
    logic              budget_out;

    // A repeated PC is a halt/spin, not a redirect, so it is excluded from redir.
    always_comb begin
        in_run     = (state == ST_RUN);
        start      = (state == ST_IDLE) && run;
        fetch      = in_run && (watch_stat == FETCH_STAT) && (prev_stat != FETCH_STAT);
        first      = (inst_cnt == '0);
        repeat_pc  = !first && (watch_pc == last_pc);
        redir      = fetch && !first && !repeat_pc && (watch_pc != last_pc + PC_W'(4));
        rep_next   = repeat_pc ? rep_cnt + REP_W'(1) : REP_W'(1);
        halt       = fetch && (rep_next == REP_W'(HALT_REPEAT));
        budget_out = in_run && (cycle_cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            prev_stat <= ~FETCH_STAT;
            rep_cnt   <= '0;
            last_pc   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state     <= ST_RUN;
                        prev_stat <= ~FETCH_STAT;
                        rep_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    prev_stat <= watch_stat;
                    if (fetch) begin
                        last_pc <= watch_pc;
                        rep_cnt <= rep_next;
                    end
                    if (halt) begin
                        state <= ST_PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (budget_out) begin
                        state   <= ST_TIMEOUT;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_inst_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (fetch),
        .q   (inst_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (redir),
        .q   (redirect_cnt)
    );

endmodule
